// File: rtl/fp_serial_tx.sv
// fp_serial_tx: FIFO-buffered start/8-data/stop serial transmitter for packed {S,E,F} float words.
module fp_serial_tx #(
  parameter int DEPTH = 4,
  parameter int BIT_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     S,
  input  logic [2:0]               E,
  input  logic [3:0]               F,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t r_state, w_next;
  logic [7:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_level;
  logic [CW-1:0] r_cyc;
  logic [2:0] r_bit;
  logic [7:0] r_shreg;
  logic r_tx;
  logic w_push, w_pop, w_avail, w_bit_end;
  assign w_avail = r_level != '0;
  assign w_bit_end = r_cyc == LAST;
  assign w_push = in_valid && in_ready;
  assign in_ready = r_level < FULL;
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  w_next = w_avail ? START : IDLE;
      START: w_next = w_bit_end ? DATA : START;
      DATA:  w_next = (w_bit_end && r_bit == 3'd7) ? STOP : DATA;
      STOP:  w_next = w_bit_end ? (w_avail ? START : IDLE) : STOP;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    busy = r_state != IDLE;
    w_pop = w_avail && (r_state == IDLE || (r_state == STOP && w_bit_end));
    tx = r_tx;
    level = r_level;
  end
  // Storage is not reset; the pointers and level alone define what is queued.
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= {S, E, F};
  always_ff @(posedge clk)
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  // The head word is taken into the shift register on the pop edge, so the start bit never waits on it.
  always_ff @(posedge clk)
    if (rst) begin
      r_tx <= 1'b1;
      r_cyc <= '0;
      r_bit <= '0;
      r_shreg <= '0;
    end else begin
      r_cyc <= (r_state == IDLE || w_bit_end) ? '0 : r_cyc + 1'b1;
      if (w_pop) begin
        r_shreg <= r_mem[r_rptr];
        r_tx <= 1'b0;
        r_bit <= '0;
      end else if (r_state == START && w_bit_end) begin
        r_tx <= r_shreg[7];
      end else if (r_state == DATA && w_bit_end) begin
        r_tx <= r_bit == 3'd7 ? 1'b1 : r_shreg[6];
        r_shreg <= r_shreg << 1;
        r_bit <= r_bit + 3'd1;
      end
    end
endmodule

// File: tb/tb_fp_serial_tx.sv
// tb_fp_serial_tx: directed checks of framing, back-to-back streaming, backpressure, wrap and reset abort.
module tb_fp_serial_tx;
  localparam int BC = 4;
  logic clk, rst, in_valid, in_ready, S, tx, busy;
  logic [2:0] E;
  logic [3:0] F;
  logic [2:0] level;
  int n_chk, n_err, cyc;
  fp_serial_tx #(.DEPTH(4), .BIT_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .S(S), .E(E), .F(F), .tx(tx), .busy(busy), .level(level)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask
  task automatic push_word(input logic [7:0] w);
    in_valid = 1'b1;
    {S, E, F} = w;
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  // Expected line: start 0, bits 7..0, stop 1, each held BC cycles, busy throughout.
  task automatic expect_frame(input logic [7:0] w);
    logic exp_bit;
    for (int k = 0; k < 10; k++) begin
      exp_bit = k == 0 ? 1'b0 : k == 9 ? 1'b1 : w[8-k];
      for (int c = 0; c < BC; c++) begin
        @(negedge clk);
        chk($sformatf("tx w%02h b%0d", w, k), 32'(tx), 32'(exp_bit));
        chk("busy in frame", 32'(busy), 32'd1);
      end
    end
  endtask
  task automatic expect_idle_empty();
    @(negedge clk);
    chk("idle tx", 32'(tx), 32'd1);
    chk("idle busy", 32'(busy), 32'd0);
    chk("idle level", 32'(level), 32'd0);
  endtask
  initial begin
    logic [7:0] wrap_words [10];
    int quiet;
    n_chk = 0;
    n_err = 0;
    S = 1'b0;
    E = '0;
    F = '0;
    do_reset();
    chk("rst tx", 32'(tx), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst level", 32'(level), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    S = 1'b1;
    E = 3'b101;
    F = 4'b0110;
    @(negedge clk);
    in_valid = 1'b0;
    chk("no bypass tx", 32'(tx), 32'd1);
    chk("no bypass busy", 32'(busy), 32'd0);
    chk("push level", 32'(level), 32'd1);
    expect_frame(8'hD6);
    expect_idle_empty();
    push_word(8'h7F);
    chk("sat pre tx", 32'(tx), 32'd1);
    expect_frame(8'h7F);
    expect_idle_empty();
    in_valid = 1'b1;
    {S, E, F} = 8'h01;
    fork
      begin
        @(negedge clk);
        {S, E, F} = 8'h80;
        @(negedge clk);
        {S, E, F} = 8'hAA;
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        @(negedge clk);
        chk("b2b pre tx", 32'(tx), 32'd1);
        expect_frame(8'h01);
        expect_frame(8'h80);
        expect_frame(8'hAA);
      end
    join
    expect_idle_empty();
    do_reset();
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          in_valid = 1'b1;
          {S, E, F} = 8'h31 + 8'(i * 17);
          @(negedge clk);
        end
        chk("fill level", 32'(level), 32'd4);
        chk("fill in_ready", 32'(in_ready), 32'd0);
        {S, E, F} = 8'hEE;
        wait_cyc(10);
        chk("held level", 32'(level), 32'd4);
        in_valid = 1'b0;
      end
      begin
        wait_cyc(1);
        for (int i = 0; i < 5; i++) expect_frame(8'h31 + 8'(i * 17));
      end
      begin
        wait_cyc(41);
        chk("full before pop", 32'(in_ready), 32'd0);
        wait_cyc(42);
        chk("ready after pop", 32'(in_ready), 32'd1);
        chk("level after pop", 32'(level), 32'd3);
      end
    join
    expect_idle_empty();
    for (int i = 0; i < 10; i++) wrap_words[i] = 8'(8'h5A ^ (i * 29));
    for (int i = 0; i < 10; i++) begin
      push_word(wrap_words[i]);
      chk("wrap pre tx", 32'(tx), 32'd1);
      chk("wrap level", 32'(level), 32'd1);
      expect_frame(wrap_words[i]);
    end
    expect_idle_empty();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      {S, E, F} = 8'hC3 ^ 8'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_cyc(60);
    chk("mid frame2 busy", 32'(busy), 32'd1);
    chk("mid frame2 level", 32'(level), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort tx", 32'(tx), 32'd1);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort level", 32'(level), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    quiet = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) quiet++;
    end
    chk("silent after abort", 32'(quiet), 32'd0);
    push_word(8'h96);
    expect_frame(8'h96);
    expect_idle_empty();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fp_serial_tx.md
# fp_serial_tx

Downstream consumer of the 12-bit-to-float converter. Accepts packed 8-bit float words {S, E[2:0], F[3:0]} through a valid/ready handshake and buffers them in a small FIFO. Transmits each word on a single-wire asynchronous-style serial line: one start bit, 8 data bits MSB-first, one stop bit. Lets the combinational converter output be captured every cycle while the slow serial link drains at its own rate.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- BIT_CYCLES, 4, clock cycles per serial bit; ≥1

- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  S/E/F present a word this cycle
- in_ready  output  1  FIFO can accept; equals (level < DEPTH)
- S  input  1  sign bit from converter
- E  input  3  exponent from converter
- F  input  4  significand from converter
- tx  output  1  serial line, idle high, registered
- busy  output  1  frame in progress (state != IDLE)
- level  output  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Word packing: word = {S, E[2], E[1], E[0], F[3], F[2], F[1], F[0]}; bit 7 sent first.
- Push: on edge with in_valid && in_ready, word written at write pointer; wptr wraps modulo DEPTH.
- Pop: occurs only on the FSM load event below; rptr wraps modulo DEPTH.
- level update per edge: +1 push only, −1 pop only, unchanged on simultaneous push and pop. No same-cycle bypass: a word pushed at edge N is poppable no earlier than edge N+1.
- in_valid while in_ready=0: word ignored, no state change, no error flag; upstream must hold.
- FSM states:
  - IDLE: tx=1. If level>0: pop head into shift register, tx<=0, bit counter<=0, go START.
  - START: hold tx=0 for BIT_CYCLES, then tx<=shreg[7], go DATA.
  - DATA: each bit held BIT_CYCLES. After the 8th bit, tx<=1, go STOP.
  - STOP: hold tx=1 for BIT_CYCLES. At the end, if level>0, pop and go START directly with tx<=0 (no idle gap). Otherwise go IDLE.
- Cycle counter: 0..BIT_CYCLES−1, wraps at bit boundary. Bit index: 0..7.
- Reset values: tx=1, busy=0, level=0, in_ready=1, wptr=rptr=0, state IDLE, counters 0, shift register 0.
- Reset mid-frame or with FIFO non-empty: frame aborted and FIFO flushed. tx=1 after the reset edge. Queued words are lost.

## Timing
- Push at edge N into an empty FIFO while IDLE: pop at edge N+1, tx low from edge N+1.
- Frame length: exactly 10×BIT_CYCLES cycles, from tx falling to the end of the stop bit.
- Back-to-back frames with the FIFO non-empty: next start bit begins on the edge ending the previous stop bit. Continuous stream, no idle cycles.
- busy rises at the pop edge. busy falls on the edge ending the stop bit only when the FIFO is empty.
- in_ready is combinational from registered level; never depends on in_valid.
- Throughput ceiling: one word per 10×BIT_CYCLES cycles. Pushes are accepted at one per cycle until full.

## Test plan
- Single word, BIT_CYCLES=4: S=1, E=3'b101, F=4'b0110 pushed at edge N → word 8'hD6. tx from edge N+1 reads 0,1,1,0,1,0,1,1,0,1, each held 4 cycles (40 cycles). busy then falls and level=0.
- Saturated value: S=0, E=7, F=15 → word 8'h7F. tx reads 0,0,1,1,1,1,1,1,1,1.
- Three words pushed on consecutive cycles (8'h01, 8'h80, 8'hAA): 120 contiguous tx cycles with no idle-high gap between stop and start bits. Bytes arrive in push order.
- Fill/backpressure, DEPTH=4, in_valid held from empty FSM: w0 popped at edge 2, level reaches 4 after edge 5. in_ready=0 afterward, so exactly 5 words are accepted. in_ready reasserts the cycle after the w0 frame's stop-bit pop of w1. All 5 words are transmitted in order.
- Wrap-around: push and transmit 10 words sequentially through DEPTH=4. Every byte is correct and pointers wrap without loss or duplication.
- Reset mid-frame: assert rst during the DATA state of the 2nd of 3 queued words. tx=1, busy=0, level=0, in_ready=1 after the edge. No further frames are emitted until a new push.
